// File: rtl/mips_shift_pkg.sv
// rtl/mips_shift_pkg.sv - shared shifter FSM states and shift-type constants
package mips_shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Shift type encoding, also used by the ALU control decoder
  localparam logic SHIFT_LOGICAL = 1'b0;
  localparam logic SHIFT_ARITH   = 1'b1;

endpackage

// File: rtl/right_shift_step.sv
// rtl/right_shift_step.sv - one partial right-shift step with fill-bit insertion
module right_shift_step #(
  parameter int WIDTH  = 32,
  parameter int STEP_W = 3
) (
  input  logic [WIDTH-1:0]  i_acc,
  input  logic [STEP_W-1:0] i_s,
  input  logic              i_fill,
  output logic [WIDTH-1:0]  o_acc
);

  logic [WIDTH-1:0] w_fill_mask;

  // Ones in the top i_s bit positions, the bits vacated by the shift
  assign w_fill_mask = ~({WIDTH{1'b1}} >> i_s);

  assign o_acc = (i_acc >> i_s) | (i_fill ? w_fill_mask : {WIDTH{1'b0}});

endmodule

// File: rtl/seq_right_shifter.sv
// rtl/seq_right_shifter.sv - multi-cycle logical/arithmetic right shifter with start/done handshake
module seq_right_shifter
  import mips_shift_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int SHAMT_W         = 5,
  parameter int SHIFT_PER_CYCLE = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   In,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   Out
);

  // Wide enough to hold 0..SHIFT_PER_CYCLE
  localparam int STEP_W = $clog2(SHIFT_PER_CYCLE + 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_acc;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_fill;
  logic [WIDTH-1:0]   r_out;
  logic               r_done;
  logic [STEP_W-1:0]  w_step;
  logic [WIDTH-1:0]   w_step_acc;

  // Step size for this cycle: whatever is left, capped at SHIFT_PER_CYCLE, so cnt never underflows
  always_comb begin
    w_step = STEP_W'(SHIFT_PER_CYCLE);
    if (r_cnt <= SHAMT_W'(SHIFT_PER_CYCLE)) begin
      w_step = r_cnt[STEP_W-1:0];
    end
  end

  right_shift_step #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_step (
    .i_acc  (r_acc),
    .i_s    (w_step),
    .i_fill (r_fill),
    .o_acc  (w_step_acc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; DONE always returns to IDLE so done is a single-cycle pulse
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = SHIFT;
      SHIFT:   if (r_cnt == '0) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, shift while cnt is nonzero, publish the result on completion
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_fill <= 1'b0;
      r_out  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc  <= In;
            r_cnt  <= shamt;
            r_fill <= (arith == SHIFT_ARITH) & In[WIDTH-1];
          end
        end
        SHIFT: begin
          if (r_cnt != '0) begin
            r_acc <= w_step_acc;
            r_cnt <= r_cnt - SHAMT_W'(w_step);
          end else begin
            r_out  <= r_acc;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (r_state == IDLE);
  assign busy  = ~ready;
  assign done  = r_done;
  assign Out   = r_out;

endmodule

// File: tb/tb_seq_right_shifter.sv
// tb/tb_seq_right_shifter.sv - scoreboard bench for seq_right_shifter
module tb_seq_right_shifter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] In = '0;
  logic [4:0]  shamt = '0;
  logic        arith = 1'b0;
  logic        ready, busy, done;
  logic [31:0] Out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] out;
    int          cyc;
  } exp_t;
  exp_t q[$];

  seq_right_shifter #(
    .WIDTH(32), .SHAMT_W(5), .SHIFT_PER_CYCLE(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .In(In), .shamt(shamt),
    .arith(arith), .ready(ready), .busy(busy), .done(done), .Out(Out)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] sh, input logic a);
    logic [63:0] w;
    w = {{32{a & d[31]}}, d} >> sh;
    return w[31:0];
  endfunction

  // Monitor: checks handshake invariants and pops the scoreboard on every done
  initial begin
    logic        prev_done;
    logic [31:0] prev_out;
    exp_t        e;
    prev_done = 1'b0;
    prev_out  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_done = 1'b0;
        prev_out  = Out;
      end else begin
        checks++;
        if (busy !== !ready) begin
          errors++;
          $display("FAIL busy_vs_ready busy=%b ready=%b cyc=%0d", busy, ready, cyc);
        end
        if (prev_done) begin
          checks++;
          if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_width done=%b exp 0 cyc=%0d", done, cyc);
          end
          checks++;
          if (ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_done ready=%b exp 1 cyc=%0d", ready, cyc);
          end
        end
        if (done === 1'b1) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL spurious_done done=1 exp 0 cyc=%0d", cyc);
          end else begin
            e = q.pop_front();
            if (Out !== e.out) begin
              errors++;
              $display("FAIL out_value got %h exp %h cyc=%0d", Out, e.out, cyc);
            end
            checks++;
            if (cyc != e.cyc) begin
              errors++;
              $display("FAIL done_latency got cyc %0d exp cyc %0d", cyc, e.cyc);
            end
          end
        end else begin
          checks++;
          if (Out !== prev_out) begin
            errors++;
            $display("FAIL out_hold got %h exp %h cyc=%0d", Out, prev_out, cyc);
          end
        end
        prev_done = done;
        prev_out  = Out;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: drop start after accept; 1: hammer start with junk while busy, drop on ready;
  // mode 2: keep start high through completion so the next issue is back-to-back
  task automatic issue(input logic [31:0] d, input logic [4:0] sh, input logic a,
                       input logic [31:0] exp_out, input int mode);
    int   w;
    exp_t e;
    w = 0;
    while (ready !== 1'b1 && w < 100) begin
      step();
      w++;
    end
    if (ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout ready=%b exp 1", ready);
      return;
    end
    In = d;
    shamt = sh;
    arith = a;
    start = 1'b1;
    e.out = exp_out;
    e.cyc = cyc + 1 + ((int'(sh) + 3) / 4) + 1;
    q.push_back(e);
    step();
    w = 0;
    while (ready !== 1'b1 && w < 100) begin
      start = (mode != 0);
      In    = $urandom;
      shamt = 5'($urandom);
      arith = 1'($urandom);
      step();
      w++;
    end
    if (mode != 2) start = 1'b0;
  endtask

  initial begin
    int w;
    logic [31:0] d;
    logic [4:0]  sh;
    logic        a;

    repeat (3) step();
    reset = 1'b0;
    checks += 4;
    if (Out !== 32'h0)   begin errors++; $display("FAIL reset_out got %h exp 0", Out); end
    if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    if (ready !== 1'b1)  begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
    if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end

    issue(32'h8000_00F0, 5'd4,  1'b0, 32'h0800_000F, 0);
    issue(32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 0);
    issue(32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF, 0);
    issue(32'h1234_5678, 5'd8,  1'b0, 32'h0012_3456, 1);
    issue(32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 2);
    issue(32'hF000_000F, 5'd5,  1'b1, 32'hFF80_0000, 2);
    issue(32'h0000_0001, 5'd0,  1'b0, 32'h0000_0001, 0);

    // Reset mid-SHIFT: the operation in flight must vanish with no done pulse
    w = 0;
    while (ready !== 1'b1 && w < 100) begin step(); w++; end
    In = 32'h8000_0000; shamt = 5'd31; arith = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    q.delete();
    repeat (2) step();
    reset = 1'b0;
    checks += 4;
    if (Out !== 32'h0)   begin errors++; $display("FAIL midreset_out got %h exp 0", Out); end
    if (done !== 1'b0)   begin errors++; $display("FAIL midreset_done got %b exp 0", done); end
    if (ready !== 1'b1)  begin errors++; $display("FAIL midreset_ready got %b exp 1", ready); end
    if (busy !== 1'b0)   begin errors++; $display("FAIL midreset_busy got %b exp 0", busy); end
    repeat (15) step();

    for (int i = 0; i < 60; i++) begin
      d  = $urandom;
      sh = 5'($urandom);
      a  = 1'($urandom);
      if (i % 10 == 0) sh = 5'd31;
      if (i % 10 == 1) sh = 5'd0;
      issue(d, sh, a, ref_shift(d, sh, a), int'($urandom_range(0, 2)));
    end
    start = 1'b0;

    w = 0;
    while (q.size() != 0 && w < 200) begin step(); w++; end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d exp 0", q.size());
    end
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
